// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group per stage, carry registered between stages.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF
);

  localparam int NSTG = WIDTH / GROUP;

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad
    $error("WIDTH must be a positive multiple of GROUP");
  end

  // Two-level lookahead: each carry is a flat OR of AND terms.
  // Bit i of the result is the carry into bit i; bit GROUP is carry-out.
  function automatic logic [GROUP:0] cla(
    input logic [GROUP-1:0] p,
    input logic [GROUP-1:0] g,
    input logic             ci
  );
    logic [GROUP:0] c;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  logic             stall;
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic             ovf_q;

  assign stall    = OUT_VALID & ~OUT_READY;
  assign IN_READY = ~stall;
  assign bx       = SUB ? ~B : B;
  assign cin      = SUB | C_IN;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int BW = WIDTH - k * GROUP;

    logic [BW-1:0]    b_in;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] x_d;
    logic [WIDTH-1:0] x_q;
    logic             c_in;
    logic             c_q;
    logic             v_in;
    logic             v_q;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   cy;

    if (k == 0) begin : g_head
      assign b_in = bx;
      assign x_in = A;
      assign c_in = cin;
      assign v_in = IN_VALID;
    end else begin : g_body
      assign b_in = g_stg[k-1].g_skew.b_q;
      assign x_in = g_stg[k-1].x_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
    end

    assign p  = x_in[k*GROUP +: GROUP] ^ b_in[GROUP-1:0];
    assign g  = x_in[k*GROUP +: GROUP] & b_in[GROUP-1:0];
    assign cy = cla(p, g, c_in);

    // x carries finished sum bits below this group and unused A bits above.
    always_comb begin
      x_d = x_in;
      x_d[k*GROUP +: GROUP] = p ^ cy[GROUP-1:0];
    end

    // Stage register; the whole pipe freezes while the output is stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (!stall) begin
        x_q <= x_d;
        c_q <= cy[GROUP];
        v_q <= v_in;
      end
    end

    if (k < NSTG - 1) begin : g_skew
      logic [BW-GROUP-1:0] b_q;

      // Skewed B operand: only groups not yet consumed travel on.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          b_q <= '0;
        end else if (!stall) begin
          b_q <= b_in[BW-1:GROUP];
        end
      end
    end
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= g_stg[NSTG-1].cy[GROUP] ^ g_stg[NSTG-1].cy[GROUP-1];
    end
  end

  assign OUT_VALID = g_stg[NSTG-1].v_q;
  assign SUM       = g_stg[NSTG-1].x_q;
  assign C_OUT     = g_stg[NSTG-1].c_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// Latency, wrap, overflow, stall/backpressure and async reset.
module tb_pipelined_cla_adder;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_IN;
  logic        SUB;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] SUM;
  logic        C_OUT;
  logic        OVF;

  int total = 0;
  int bad   = 0;

  pipelined_cla_adder #(
    .WIDTH(16),
    .GROUP(4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .A        (A),
    .B        (B),
    .C_IN     (C_IN),
    .SUB      (SUB),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM      (SUM),
    .C_OUT    (C_OUT),
    .OVF      (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, carry, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic ci,
                                         input logic sb);
    logic [16:0] w;
    logic [15:0] s;
    logic        c;
    logic        o;
    if (sb) begin
      s = a - b;
      c = (a >= b);
      o = (a[15] != b[15]) && (s[15] != a[15]);
    end else begin
      w = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      s = w[15:0];
      c = w[16];
      o = (a[15] == b[15]) && (s[15] != a[15]);
    end
    return {o, c, s};
  endfunction

  function automatic logic [15:0] opa(input int i);
    return 16'(32'h0F00 + i * 32'h2345);
  endfunction

  function automatic logic [15:0] opb(input int i);
    return 16'(32'h1357 * (i + 1));
  endfunction

  // One isolated op: checks latency of 4 edges and the result.
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic ci,
                        input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    A = a;
    B = b;
    C_IN = ci;
    SUB = sb;
    OUT_READY = 1'b1;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk({tag, "_early"}, OUT_VALID, 0);
    @(posedge CLK); #1;
    chk({tag, "_vld"}, OUT_VALID, 1);
    chk({tag, "_sum"}, SUM, es);
    chk({tag, "_cout"}, C_OUT, ec);
    chk({tag, "_ovf"}, OVF, eo);
    @(posedge CLK); #1;
  endtask

  int          sent;
  int          rcv;
  int          stall_left;
  bit          stalled_once;
  bit          acc;
  logic [17:0] m;

  initial begin
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    A = '0;
    B = '0;
    C_IN = 1'b0;
    SUB = 1'b0;
    #1;
    chk("rst_vld", OUT_VALID, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_cout", C_OUT, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_rdy", IN_READY, 1);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("novf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("sovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sbor", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sign", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Six back-to-back ops with a 3-cycle output stall.
    sent = 0;
    rcv = 0;
    stall_left = 0;
    stalled_once = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      if (!stalled_once && OUT_VALID) begin
        stalled_once = 1'b1;
        stall_left = 3;
      end
      OUT_READY = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      IN_VALID = (sent < 6);
      A = opa(sent);
      B = opb(sent);
      SUB = sent[0];
      C_IN = 1'b0;
      #1;
      m = ref_op(opa(rcv), opb(rcv), 1'b0, rcv[0]);
      if (!OUT_READY) begin
        chk("stall_rdy", IN_READY, 0);
        chk("stall_sum", SUM, m[15:0]);
      end
      if (OUT_VALID && OUT_READY) begin
        chk($sformatf("strm_sum%0d", rcv), SUM, m[15:0]);
        chk($sformatf("strm_cout%0d", rcv), C_OUT, m[16]);
        chk($sformatf("strm_ovf%0d", rcv), OVF, m[17]);
        rcv++;
      end
      acc = IN_VALID && IN_READY;
      @(posedge CLK); #1;
      if (acc) sent++;
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    chk("strm_count", rcv, 6);
    chk("strm_stalled", stalled_once, 1);
    repeat (3) begin
      chk("no_dup", OUT_VALID, 0);
      @(posedge CLK); #1;
    end

    // Async reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      A = opa(i);
      B = opb(i);
      SUB = 1'b0;
      IN_VALID = 1'b1;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("pre_rst_vld", OUT_VALID, 1);
    RST_N = 1'b0;
    #1;
    chk("arst_vld", OUT_VALID, 0);
    chk("arst_sum", SUM, 0);
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("post_rst%0d", i), OUT_VALID, 0);
    end
    run_op("after", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
